rr_arbiter_4: RTL

// - Responder side of the 4-requester req/gnt/eot arbitration handshake; the DUT the arbiter UVM bench drives.
// - Grants one requester at a time with round-robin fairness.
// - The grant is held until the owner pulses its end-of-transfer (eot).
// - Sits between four bus masters and a shared resource; purely synchronous control, no datapath.

---
 rtl/rr_arbiter_4.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/rr_arbiter_4.sv
// rtl/rr_arbiter_4.sv - four-requester round-robin arbiter with eot-released grants
//
// Purpose:
//   Grants one of four requesters at a time in round-robin order. A grant is
//   held until the owner pulses its end-of-transfer. Every grant is followed by
//   at least one cycle with all grants low. Optional watchdog (macro
//   RRA_TIMEOUT_EN) revokes a grant held TIMEOUT_CYCLES cycles without eot.
//
// Ports:
//   clk          in   clock, all logic on posedge
//   rstn         in   asynchronous active-low reset
//   req0..req3   in   level requests
//   eot0..eot3   in   one-cycle end-of-transfer pulses
//   gnt0..gnt3   out  registered grants, one-hot or zero
//   eot_err      out  one-cycle pulse, eot from a requester that is not the owner
//   timeout      out  one-cycle pulse, grant revoked by the watchdog (0 without RRA_TIMEOUT_EN)

module rr_arbiter_4 #(
  parameter int unsigned RESET_PTR      = 0,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rstn,
  input  logic req0,
  input  logic req1,
  input  logic req2,
  input  logic req3,
  input  logic eot0,
  input  logic eot1,
  input  logic eot2,
  input  logic eot3,
  output logic gnt0,
  output logic gnt1,
  output logic gnt2,
  output logic gnt3,
  output logic eot_err,
  output logic timeout
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [1:0] PTR_INIT = 2'(RESET_PTR);

  logic [0:0] state;
  logic [1:0] ptr;
  logic [1:0] owner;
  logic [3:0] gnt;
  logic [3:0] req_v;
  logic [3:0] eot_v;
  logic [3:0] owner_mask;
  logic [1:0] win;
  logic       eot_own;
  logic       eot_stray;
  logic       wd_fire;

  assign req_v      = {req3, req2, req1, req0};
  assign eot_v      = {eot3, eot2, eot1, eot0};
  assign owner_mask = 4'b0001 << owner;

  // The owner mask is only meaningful while BUSY; in IDLE every eot is stray.
  assign eot_own   = (state == BUSY) && |(eot_v & owner_mask);
  assign eot_stray = (state == BUSY) ? |(eot_v & ~owner_mask) : |eot_v;

  // First requesting index scanning ptr, ptr+1, ptr+2, ptr+3 (mod 4).
  always_comb begin
    logic       found;
    logic [1:0] cand;
    win   = ptr;
    found = 1'b0;
    cand  = ptr;
    for (int k = 0; k < 4; k++) begin
      cand = ptr + 2'(k);
      if (!found && req_v[cand]) begin
        win   = cand;
        found = 1'b1;
      end
    end
  end

`ifdef RRA_TIMEOUT_EN
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] cnt;
  logic        timeout_q;

  // An owner eot on the last allowed cycle takes precedence over the watchdog.
  assign wd_fire = (state == BUSY) && !eot_own && (cnt == CNT_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= 16'd0;
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= wd_fire;
      // Held at zero in IDLE so a fresh grant always starts counting from 0.
      if (state == IDLE || eot_own || wd_fire) begin
        cnt <= 16'd0;
      end else begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign timeout = timeout_q;
`else
  assign wd_fire = 1'b0;
  assign timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      ptr     <= PTR_INIT;
      owner   <= 2'd0;
      gnt     <= 4'b0000;
      eot_err <= 1'b0;
    end else begin
      eot_err <= eot_stray;
      case (state)
        IDLE: begin
          if (|req_v) begin
            gnt   <= 4'b0001 << win;
            owner <= win;
            ptr   <= win + 2'd1;
            state <= BUSY;
          end
        end
        BUSY: begin
          // Release goes back through IDLE, which forces the all-low cycle.
          if (eot_own || wd_fire) begin
            gnt   <= 4'b0000;
            state <= IDLE;
          end
        end
        default: begin
          gnt   <= 4'b0000;
          state <= IDLE;
        end
      endcase
    end
  end

  assign gnt0 = gnt[0];
  assign gnt1 = gnt[1];
  assign gnt2 = gnt[2];
  assign gnt3 = gnt[3];

endmodule
